// File: rtl/inst_buffer_pkg.sv
// Shared fetch-side constants and the instruction-buffer entry type.
package inst_buffer_pkg;

  localparam logic RST_EN        = 1'b1;
  localparam int   CPU_ADDR_BUS  = 32;
  localparam int   SRAM_DATA_BUS = 32;
  localparam logic [SRAM_DATA_BUS-1:0] INST_NOOP = '0;
  localparam int   IBUF_DEPTH    = 4;

  typedef struct packed {
    logic [CPU_ADDR_BUS-1:0]  pc;
    logic [SRAM_DATA_BUS-1:0] inst;
  } ibuf_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic DEPTH x W register FIFO with synchronous clear and a combinational head.
module sync_fifo
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Storage is not reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_EN || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_buffer.sv
// Fetch instruction buffer: tracks SRAM reads issued by pc, queues {pc, inst}
// pairs for ID, and back-pressures pc by credit so the queue cannot overflow.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH  = IBUF_DEPTH,
  parameter int ADDR_W = CPU_ADDR_BUS,
  parameter int DATA_W = SRAM_DATA_BUS
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     FETCH_CE,
  input  logic [ADDR_W-1:0]        FETCH_ADDR,
  input  logic [DATA_W-1:0]        SRAM_INST_RDATA,
  output logic                     STALL_PC,
  input  logic                     FLUSH,
  input  logic                     ID_READY,
  output logic                     ID_VALID,
  output logic [ADDR_W-1:0]        ID_PC,
  output logic [DATA_W-1:0]        ID_INST,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic              req_v;
  logic              req_kill;
  logic [ADDR_W-1:0] req_pc;
  logic              issue;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;

  // Credit: one slot is reserved for every read still in flight. Only
  // registered state and FLUSH feed this, so ID_READY never reaches pc.
  assign STALL_PC = ((COUNT + CW'(req_v)) >= DEPTH_C) && !FLUSH;
  assign issue    = FETCH_CE && !STALL_PC;

  // The response landing in a FLUSH cycle belongs to the squashed path.
  assign push = req_v && !req_kill && !FLUSH;

  // ID handshake: an entry moves to ID in any cycle where ID_VALID and
  // ID_READY are both high; ID_VALID never depends on ID_READY.
  assign pop  = ID_VALID && ID_READY;

  always_ff @(posedge CLK) begin
    if (RST == RST_EN) begin
      req_v    <= 1'b0;
      req_kill <= 1'b0;
      req_pc   <= '0;
    end else begin
      req_v    <= issue;
      req_kill <= FLUSH;
      if (issue) req_pc <= FETCH_ADDR;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data ({req_pc, SRAM_INST_RDATA}),
    .pop       (pop),
    .clear     (FLUSH),
    .count     (COUNT),
    .head      (head)
  );

  assign ID_VALID = (COUNT != '0);
  assign ID_PC    = ID_VALID ? head[EW-1:DATA_W] : '0;
  assign ID_INST  = ID_VALID ? head[DATA_W-1:0]  : DATA_W'(INST_NOOP);

  always_ff @(posedge CLK) begin
    if (RST != RST_EN) begin
      assert (!(push && COUNT == DEPTH_C));
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized and directed bench for inst_buffer against a queue-level reference model.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FETCH_CE;
  logic [31:0] FETCH_ADDR;
  logic [31:0] SRAM_INST_RDATA;
  logic        STALL_PC;
  logic        FLUSH;
  logic        ID_READY;
  logic        ID_VALID;
  logic [31:0] ID_PC;
  logic [31:0] ID_INST;
  logic [2:0]  COUNT;

  always #5 CLK = ~CLK;

  inst_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .FETCH_CE        (FETCH_CE),
    .FETCH_ADDR      (FETCH_ADDR),
    .SRAM_INST_RDATA (SRAM_INST_RDATA),
    .STALL_PC        (STALL_PC),
    .FLUSH           (FLUSH),
    .ID_READY        (ID_READY),
    .ID_VALID        (ID_VALID),
    .ID_PC           (ID_PC),
    .ID_INST         (ID_INST),
    .COUNT           (COUNT)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference state: queued pairs, the one outstanding read, and the pc model.
  logic [63:0] exp_q[$];
  logic        infl_v    = 1'b0;
  logic        infl_kill = 1'b0;
  logic [31:0] infl_pc   = '0;
  logic [31:0] pc_addr   = 32'hBFC00000;
  logic [31:0] last_addr = '0;
  bit          known     = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic ce, input logic rdy, input logic fl, input logic rs,
                      input logic [31:0] tgt);
    logic        exp_stall;
    logic        exp_valid;
    logic        issue;
    logic        push;
    logic        pop;
    ibuf_entry_t hd;
    FETCH_CE        = ce;
    ID_READY        = rdy;
    FLUSH           = fl;
    RST             = rs;
    FETCH_ADDR      = pc_addr;
    SRAM_INST_RDATA = last_addr ^ 32'h0000FFFF;
    @(negedge CLK);
    exp_stall = ((exp_q.size() + int'(infl_v)) >= DEPTH) && !fl;
    exp_valid = exp_q.size() != 0;
    if (exp_valid) hd = ibuf_entry_t'(exp_q[0]);
    else begin
      hd.pc   = '0;
      hd.inst = INST_NOOP;
    end
    if (known) begin
      chk("valid", 64'(ID_VALID), 64'(exp_valid));
      chk("pc",    64'(ID_PC),    64'(hd.pc));
      chk("inst",  64'(ID_INST),  64'(hd.inst));
      chk("count", 64'(COUNT),    64'(exp_q.size()));
      chk("stall", 64'(STALL_PC), 64'(exp_stall));
    end
    issue = ce && !exp_stall;
    push  = infl_v && !infl_kill && !fl;
    pop   = exp_valid && rdy;
    if (rs) begin
      exp_q.delete();
      infl_v    = 1'b0;
      infl_kill = 1'b0;
      known     = 1;
    end else begin
      if (fl) exp_q.delete();
      else begin
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back({infl_pc, infl_pc ^ 32'h0000FFFF});
      end
      infl_v    = issue;
      infl_kill = fl;
      infl_pc   = pc_addr;
      if (fl)         pc_addr = tgt;
      else if (issue) pc_addr = pc_addr + 32'd4;
    end
    last_addr = FETCH_ADDR;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    RST = 1'b1; FETCH_CE = 1'b0; FLUSH = 1'b0; ID_READY = 1'b0;
    FETCH_ADDR = '0; SRAM_INST_RDATA = '0;
    @(posedge CLK);
    #1;

    // Reset with random inputs
    repeat (2) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b1, $urandom);
    chk("reset_valid", 64'(ID_VALID), 64'(1'b0));
    chk("reset_count", 64'(COUNT),    64'(0));
    chk("reset_stall", 64'(STALL_PC), 64'(1'b0));
    chk("reset_inst",  64'(ID_INST),  64'(INST_NOOP));
    chk("reset_pc",    64'(ID_PC),    64'(0));

    // Streaming at full rate
    pc_addr = 32'hBFC00000;
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("stream_not_yet", 64'(ID_VALID), 64'(1'b0));
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("stream_first_valid", 64'(ID_VALID), 64'(1'b1));
    chk("stream_first_pc",    64'(ID_PC),    64'(32'hBFC00000));
    chk("stream_first_inst",  64'(ID_INST),  64'(32'hBFC0FFFF));
    repeat (12) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("stream_count", 64'(COUNT), 64'(1));

    // Backpressure then drain
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    pc_addr = 32'hBFC00000;
    repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("bp_count", 64'(COUNT),    64'(4));
    chk("bp_stall", 64'(STALL_PC), 64'(1'b1));
    chk("bp_head",  64'(ID_PC),    64'(32'hBFC00000));
    repeat (12) step(1'b1, 1'b1, 1'b0, 1'b0, '0);

    // Flush with three queued and one in flight
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    pc_addr = 32'hBFC00000;
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("fl_pre_count", 64'(COUNT), 64'(3));
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'hBFC00100);
    chk("fl_count_t1", 64'(COUNT), 64'(0));
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("fl_count_t2", 64'(COUNT), 64'(0));
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("fl_first_valid", 64'(ID_VALID), 64'(1'b1));
    chk("fl_first_pc",    64'(ID_PC),    64'(32'hBFC00100));

    // Flush while full and stalled
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    pc_addr = 32'hBFC00000;
    repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("fs_stall", 64'(STALL_PC), 64'(1'b1));
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'hBFC00200);
    chk("fs_count", 64'(COUNT), 64'(0));
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, '0);

    // Reset mid-operation
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    pc_addr = 32'hBFC00000;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("rm_count_pre", 64'(COUNT), 64'(2));
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    chk("rm_count", 64'(COUNT),    64'(0));
    chk("rm_valid", 64'(ID_VALID), 64'(1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("rm_stale", 64'(COUNT), 64'(0));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0),
           {20'hBFC00, 10'($urandom_range(0, 1023)), 2'b00});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Fetch-side instruction buffer between the `pc` stage and the ID stage. It tracks each SRAM instruction read issued by `pc` and captures the returned word one cycle later, tagged with its fetch address. It queues up to `DEPTH` {pc, inst} pairs and presents them in order to ID through a valid/ready handshake. It back-pressures `pc` through `STALL_PC` so the queue never overflows, and discards all queued and in-flight instructions on `FLUSH`.

## Interface
- `DEPTH`, 4: queue entries. Power of two, ≥ 2.
- `ADDR_W`, 32: fetch address width (`CPU_ADDR_BUS`).
- `DATA_W`, 32: instruction width (`SRAM_DATA_BUS`).

- `CLK` in 1: clock.
- `RST` in 1: reset, synchronous, active-high.
- `FETCH_CE` in 1: copy of `pc`'s `SRAM_INST_CE`.
- `FETCH_ADDR` in `ADDR_W`: copy of `pc`'s `SRAM_INST_VADDR`.
- `SRAM_INST_RDATA` in `DATA_W`: SRAM read data, valid the cycle after the address is presented.
- `STALL_PC` out 1: drives `pc.STALL`. 1 = hold pc.
- `FLUSH` in 1: one-cycle squash request from ID/EX (branch redirect, exception).
- `ID_READY` in 1: ID accepts the head entry this cycle.
- `ID_VALID` out 1: head entry valid.
- `ID_PC` out `ADDR_W`: head entry fetch address.
- `ID_INST` out `DATA_W`: head entry instruction.
- `COUNT` out clog2(`DEPTH`)+1: queued entries, for debug and perf counters.

## Operation
- **Issue**
  - A fetch is issued in cycle t iff `FETCH_CE`=1 and `STALL_PC`=0 in t.
  - A stalled cycle re-presents the same address. No fetch is counted and the returned data is ignored.
- **In-flight register**
  - On issue, latch `req_v`=1 and `req_pc`=`FETCH_ADDR`, plus a `req_kill` bit.
  - Otherwise `req_v`←0.
- **Response**
  - In cycle t+1, if `req_v`=1 and `req_kill`=0, push {`req_pc`, `SRAM_INST_RDATA`} into the queue.
- **Pop**
  - When `ID_VALID`=1 and `ID_READY`=1, drop the head.
  - Push and pop in the same cycle leave `COUNT` unchanged.
- **Credit rule**
  - `STALL_PC` = (`COUNT` + `req_v` ≥ `DEPTH`) & ~`FLUSH`.
  - Computed only from registered state plus `FLUSH`. There is no path from `ID_READY`.
  - This guarantees a push never meets a full queue. Push-when-full is unreachable and is covered by an assertion.
- **FLUSH in cycle t**
  - At the end of t, empty the queue (`COUNT`←0).
  - The response arriving in t (fetch issued t−1) is not pushed.
  - The fetch issued in t (old sequential address; `pc` loads the target at this edge) is latched with `req_kill`=1, and its response in t+1 is dropped.
  - `STALL_PC` is forced to 0 in t so `pc` accepts the branch target.
  - The first entry kept is the fetch issued in t+1.
- **FLUSH policy**
  - The block does not interpret delay slots. The `FLUSH` source must hold off until the delay slot has been popped.
- **Head outputs**
  - `ID_PC` and `ID_INST` are read combinationally from the head entry.
  - When empty they are forced to 0 and `INST_NOOP`.
- **Reset values**
  - `COUNT`=0, `ID_VALID`=0, `ID_PC`=0, `ID_INST`=`INST_NOOP`, `STALL_PC`=0.
  - Pointers = 0, `req_v`=0, `req_kill`=0.
- **Reset mid-operation**
  - All entries are dropped and the in-flight response is ignored.
  - `RST` takes priority over `FLUSH`, push and pop.

## Timing
- Fetch issued in t → data sampled in t+1 → `ID_VALID` in t+2. Minimum latency 2 cycles.
- Sustained throughput is 1 instruction/cycle when `ID_READY`=1. The steady state holds `COUNT`≤1 and `req_v`=1, so `STALL_PC`=0.
- With `ID_READY`=0, `STALL_PC` rises once `COUNT`+`req_v`=`DEPTH`. After the first pop it falls the next cycle.
- Pointers are clog2(`DEPTH`) bits and wrap modulo `DEPTH`. `COUNT` saturates at `DEPTH` by construction.

## Structure
- `defines.vh` holds `RST_EN`, `INST_NOOP`, `CPU_ADDR_BUS` and `SRAM_DATA_BUS`.
- Add `IBUF_DEPTH` (default 4) and an `ibuf_entry_t` packed struct {pc, inst} to the shared package.
- Sub-module `sync_fifo`: generic `DEPTH`×W register FIFO with push, pop, clear, count and head.
- `inst_buffer` keeps the issue/kill tracking, the credit rule and the output muxing.

## Test plan
1. **Reset:** `RST`=1 for 2 cycles, random inputs → `ID_VALID`=0, `COUNT`=0, `STALL_PC`=0, `ID_INST`=`INST_NOOP`, `ID_PC`=0.
2. **Streaming:** `FETCH_CE`=1, addresses 0xBFC00000, +4, …, `RDATA`=addr^0xFFFF, `ID_READY`=1 → first `ID_VALID` 2 cycles after the first issue, pairs in order, `STALL_PC` never 1.
3. **Backpressure:** `ID_READY`=0 while streaming → `STALL_PC`=1 once `COUNT`=3 with `req_v`=1; `COUNT` ends at 4; address 0xBFC00010 presented 5 cycles is pushed once; then `ID_READY`=1 → 0xBFC00000…0xBFC00010 drain in order, no loss or duplicate.
4. **Flush:** 3 entries queued plus one in flight, `FLUSH`=1 in t, `pc` redirected to 0xBFC00100 → `COUNT`=0 in t+1, responses in t and t+1 dropped, first `ID_PC`=0xBFC00100 at t+3.
5. **Flush while stalled:** `COUNT`=4, `FLUSH`=1 → `STALL_PC`=0 in that cycle, queue empty in the next.
6. **Reset mid-operation:** `COUNT`=2 with a fetch in flight, `RST` for 1 cycle → next cycle `COUNT`=0, `ID_VALID`=0, stale response not pushed.
